// File: rtl/ysyx_23060042_mdu_if.sv
// Request/response bus between a requester and the iterative multiply/divide unit.
// The requester drives the operation and flush; the unit drives handshake status and the result.
interface ysyx_23060042_mdu_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output flush, in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  flush, in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/ysyx_23060042_mdu.sv
// Iterative RV-style multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction applied on the last step.
module ysyx_23060042_mdu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_23060042_mdu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   res_q;
  logic [2:0]         op_q;
  logic               neg_q;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out       = res_q;

  // Request decode: effective signs, magnitudes and the divide short-cuts
  logic             sgn1, sgn2, s1, s2, neg_in, div_zero, div_ovf;
  logic [WIDTH-1:0] mag1, mag2, byp_res;

  always_comb begin
    sgn1     = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    sgn2     = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    s1       = sgn1 & bus.data1[WIDTH-1];
    s2       = sgn2 & bus.data2[WIDTH-1];
    mag1     = neg_w(bus.data1, s1);
    mag2     = neg_w(bus.data2, s2);
    neg_in   = (bus.op[2] && bus.op[1]) ? s1 : (s1 ^ s2);
    div_zero = bus.op[2] && (bus.data2 == '0);
    div_ovf  = bus.op[2] && !bus.op[0] && (bus.data2 == '1) &&
               (bus.data1 == {1'b1, {(WIDTH-1){1'b0}}});
    byp_res  = '0;
    if (div_zero)     byp_res = bus.op[1] ? bus.data1 : '1;
    else if (div_ovf) byp_res = bus.op[1] ? '0 : bus.data1;
  end

  // One iteration step; acc holds {hi, lo} for multiply and {remainder, quotient} for divide
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] acc_nx, prod;
  logic [WIDTH-1:0]   result;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    if (!op_q[2])     acc_nx = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH]) acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod = neg_2w(acc_nx, neg_q);
    if (!op_q[2])     result = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (op_q[1]) result = neg_w(acc_nx[2*WIDTH-1:WIDTH], neg_q);
    else              result = neg_w(acc_nx[WIDTH-1:0], neg_q);
  end

  // Control FSM: reset beats flush, flush beats acceptance and completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      res_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          neg_q <= neg_in;
          opnd  <= bus.op[2] ? mag2 : mag1;
          cnt   <= CW'(WIDTH);
          if (div_zero || div_ovf) begin
            res_q <= byp_res;
            state <= DONE;
          end else begin
            acc   <= bus.op[2] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_q <= result;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060042_mdu.sv
// Directed bench for the multiply/divide unit at WIDTH=32 with hand-computed results.
module tb_ysyx_23060042_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060042_mdu_if #(.WIDTH(W)) bus ();
  ysyx_23060042_mdu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   nvec = 0;
  int   nerr = 0;
  logic watch = 1'b0;
  logic seen_v = 1'b0;

  always @(negedge clk) if (watch && bus.out_valid) seen_v <= 1'b1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [2:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2);
    bus.op = op; bus.data1 = d1; bus.data2 = d2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(exp_lat));
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " in_ready after release"}, W'(bus.in_ready), W'(1));
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] d1,
                     input logic [W-1:0] d2, input logic [W-1:0] exp, input int lat);
    start(op, d1, d2);
    wait_valid(tag, lat);
    chk(tag, bus.out, exp);
    release_out(tag);
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'b000; bus.data1 = '0; bus.data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", W'(bus.in_ready), W'(1));
    chk("reset out_valid", W'(bus.out_valid), W'(0));
    chk("reset busy", W'(bus.busy), W'(0));
    chk("reset out", bus.out, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("MUL -1*-1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, W);
    run("MULH -1*-1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, W);
    run("MULHSU -1*max",3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, W);
    run("MULHU max*max",3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W);
    run("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, W);
    run("DIV -7/2",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, W);
    run("REM -7/2",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, W);
    run("DIVU fff9/2",  3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, W);
    run("DIV 100/7",    3'b100, 32'd100,      32'd7,        32'd14,       W);
    run("REM 100/-7",   3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        W);
    run("DIV -100/7",   3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, W);
    run("REMU 100/7",   3'b111, 32'd100,      32'd7,        32'd2,        W);
    run("DIVU 7/0",     3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 0);
    run("REMU 7/0",     3'b111, 32'd7,        32'd0,        32'h00000007, 0);
    run("DIV min/-1",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run("REM min/-1",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

    // operands change mid-CALC; request held high across DONE->IDLE
    start(3'b000, 32'd6, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    bus.data1 = 32'd99; bus.data2 = 32'd12345; bus.op = 3'b101;
    chk("mid-CALC in_ready", W'(bus.in_ready), W'(0));
    chk("mid-CALC busy", W'(bus.busy), W'(1));
    wait_valid("MUL 6*7 changed inputs", W - 3);
    chk("MUL 6*7 changed inputs", bus.out, 32'd42);
    bus.in_valid = 1'b1;
    release_out("DONE->IDLE no accept");
    chk("DONE->IDLE busy", W'(bus.busy), W'(0));
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // backpressure in DONE
    start(3'b000, 32'd3, 32'd5);
    wait_valid("bp MUL", W);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out stable", bus.out, 32'h0000000F);
      chk("bp in_ready", W'(bus.in_ready), W'(0));
      chk("bp busy", W'(bus.busy), W'(1));
    end
    release_out("bp");

    // flush at iteration 10
    start(3'b101, 32'hFFFFFFF9, 32'd2);
    repeat (9) begin @(posedge clk); #1; end
    seen_v = 1'b0; watch = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush in_ready", W'(bus.in_ready), W'(1));
    chk("flush out_valid", W'(bus.out_valid), W'(0));
    repeat (40) begin @(posedge clk); #1; end
    watch = 1'b0;
    chk("flush no out_valid", W'(seen_v), W'(0));
    run("MUL 3*5 after flush", 3'b000, 32'd3, 32'd5, 32'h0000000F, W);

    // reset mid-CALC
    start(3'b000, 32'd1234, 32'd5678);
    repeat (5) begin @(posedge clk); #1; end
    seen_v = 1'b0; watch = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst mid-CALC out", bus.out, 32'h0);
    chk("rst mid-CALC in_ready", W'(bus.in_ready), W'(1));
    chk("rst mid-CALC out_valid", W'(bus.out_valid), W'(0));
    repeat (40) begin @(posedge clk); #1; end
    watch = 1'b0;
    chk("rst no out_valid", W'(seen_v), W'(0));
    run("MULHU after reset", 3'b011, 32'h80000000, 32'h00000004, 32'h00000002, W);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
